// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_share_ctrl : round-robin time-sharing of one external ripple adder
// Rev 1.0
// ----------------------------------------------------------------------------
module adder_share_ctrl #(
  parameter int  NUM_REQ = 4,
  parameter int  WIDTH   = 16,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]       req_sub_i,
  output logic [WIDTH-1:0]         adder_a_o,
  output logic [WIDTH-1:0]         adder_b_o,
  input  logic [WIDTH-1:0]         adder_s_i,
  input  logic                     adder_cout_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [WIDTH-1:0]         res_data_o,
  output logic                     res_carry_o,
  output logic [IDW-1:0]           res_id_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_ADD  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic               c1_q;
  logic               res_valid_q;
  logic [WIDTH-1:0]   res_data_q;
  logic               res_carry_q;
  logic [IDW-1:0]     res_id_q;

  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     ptr_d;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_valid_i[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  assign ptr_d = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
  assign sel_a = req_a_i[win*WIDTH +: WIDTH];
  assign sel_b = req_b_i[win*WIDTH +: WIDTH];

  // Grant is gated by rst_n so no requester sees a handshake while reset is held.
  always_comb begin
    req_ready_o = '0;
    if (rst_n && (state_q == S_IDLE) && found) req_ready_o[win] = 1'b1;
  end

  always_comb begin
    adder_a_o = '0;
    adder_b_o = '0;
    case (state_q)
      S_NEG: begin
        adder_a_o = ~opb_q;
        adder_b_o = WIDTH'(1);
      end
      S_ADD: begin
        adder_a_o = opa_q;
        adder_b_o = opb_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      c1_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            opa_q   <= sel_a;
            opb_q   <= sel_b;
            id_q    <= win;
            ptr_q   <= ptr_d;
            c1_q    <= 1'b0;
            state_q <= req_sub_i[win] ? S_NEG : S_ADD;
          end
        end
        S_NEG: begin
          // Carry out of ~B + 1 only occurs for B == 0, where A - 0 never borrows.
          opb_q   <= adder_s_i;
          c1_q    <= adder_cout_i;
          state_q <= S_ADD;
        end
        S_ADD: begin
          res_data_q  <= adder_s_i;
          res_carry_q <= adder_cout_i | c1_q;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_carry_o = res_carry_q;
  assign res_id_o    = res_id_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire
